// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the MSP430-style register file: special register
// indices, source addressing modes and constant-generator values.
package reg_file_mp_pkg;

    localparam int REG_PC = 0;
    localparam int REG_SP = 1;
    localparam int REG_SR = 2;
    localparam int REG_CG = 3;

    typedef enum logic [1:0] {
        AS_REG = 2'b00,
        AS_IDX = 2'b01,
        AS_IND = 2'b10,
        AS_INC = 2'b11
    } as_mode_t;

    localparam int CG_ZERO  = 0;
    localparam int CG_ONE   = 1;
    localparam int CG_TWO   = 2;
    localparam int CG_FOUR  = 4;
    localparam int CG_EIGHT = 8;

endpackage

// File: rtl/reg_file_mp_if.sv
// Operand/control bus between decode, the register file and the ALU.
// The master drives selects, write data and loads; the slave returns operands.
interface reg_file_mp_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] SA;
    logic [ADDR_W-1:0] DA;
    logic [1:0]        As;
    logic              BW;
    logic              RW;
    logic [DATA_W-1:0] Din;
    logic              AINC;
    logic [DATA_W-1:0] reg_PC_in;
    logic [DATA_W-1:0] reg_SP_in;
    logic [DATA_W-1:0] reg_SR_in;
    logic              PC_LD;
    logic              SP_LD;
    logic              SR_LD;
    logic [DATA_W-1:0] Sout;
    logic [DATA_W-1:0] Dout;
    logic [DATA_W-1:0] reg_PC_out;
    logic [DATA_W-1:0] reg_SP_out;
    logic [DATA_W-1:0] reg_SR_out;
    logic              CG_hit;

    modport master (
        output SA, DA, As, BW, RW, Din, AINC,
        output reg_PC_in, reg_SP_in, reg_SR_in, PC_LD, SP_LD, SR_LD,
        input  Sout, Dout, reg_PC_out, reg_SP_out, reg_SR_out, CG_hit
    );

    modport slave (
        input  SA, DA, As, BW, RW, Din, AINC,
        input  reg_PC_in, reg_SP_in, reg_SR_in, PC_LD, SP_LD, SR_LD,
        output Sout, Dout, reg_PC_out, reg_SP_out, reg_SR_out, CG_hit
    );

endinterface

// File: rtl/reg_file_mp_cg.sv
// Constant generator: R2 with a non-register mode and every R3 access
// produce an immediate instead of a register value.
module reg_file_mp_cg
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic [ADDR_W-1:0] sa,
    input  logic [1:0]        as_mode,
    output logic [DATA_W-1:0] cg_val,
    output logic              cg_hit
);

    localparam logic [ADDR_W-1:0] A_SR = ADDR_W'(REG_SR);
    localparam logic [ADDR_W-1:0] A_CG = ADDR_W'(REG_CG);

    always_comb begin
        cg_val = '0;
        cg_hit = 1'b0;
        if (sa == A_SR && as_mode != AS_REG) begin
            cg_hit = 1'b1;
            case (as_mode)
                AS_IND:  cg_val = DATA_W'(CG_FOUR);
                AS_INC:  cg_val = DATA_W'(CG_EIGHT);
                default: cg_val = DATA_W'(CG_ZERO);
            endcase
        end else if (sa == A_CG) begin
            cg_hit = 1'b1;
            case (as_mode)
                AS_IDX:  cg_val = DATA_W'(CG_ONE);
                AS_IND:  cg_val = DATA_W'(CG_TWO);
                AS_INC:  cg_val = '1;
                default: cg_val = DATA_W'(CG_ZERO);
            endcase
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised MSP430-style register file with PC/SP/SR/CG specials,
// byte writes, @Rn+ post-increment, write-through bypass and fixed write priority.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] RST_VEC,
    reg_file_mp_if.slave      bus
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] A_PC = ADDR_W'(REG_PC);
    localparam logic [ADDR_W-1:0] A_SP = ADDR_W'(REG_SP);
    localparam logic [ADDR_W-1:0] A_SR = ADDR_W'(REG_SR);
    localparam logic [ADDR_W-1:0] A_CG = ADDR_W'(REG_CG);

    logic [DATA_W-1:0] rd_arr [NREGS];
    logic [DATA_W-1:0] wr_val;
    logic [DATA_W-1:0] inc_val;
    logic [DATA_W-1:0] cg_val;
    logic              cg_hit;
    logic              inc_en;

    reg_file_mp_cg #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_cg (
        .sa      (bus.SA),
        .as_mode (bus.As),
        .cg_val  (cg_val),
        .cg_hit  (cg_hit)
    );

    // PC and SP are word-aligned, so their LSB can never be written as 1.
    always_comb begin
        wr_val = bus.BW ? {{(DATA_W-8){1'b0}}, bus.Din[7:0]} : bus.Din;
        if (bus.DA == A_PC || bus.DA == A_SP) begin
            wr_val[0] = 1'b0;
        end
    end

    assign inc_en  = bus.AINC && (bus.As == AS_INC) && (bus.SA != A_SR) && (bus.SA != A_CG);
    assign inc_val = rd_arr[bus.SA] +
                     ((bus.BW && (bus.SA > A_SP)) ? DATA_W'(1) : DATA_W'(2));

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
        if (gi == REG_CG) begin : g_const
            assign rd_arr[gi] = '0;
        end else begin : g_store
            localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);
            logic [DATA_W-1:0] r_q;
            logic [DATA_W-1:0] r_d;

            // Write port beats post-increment, which beats the dedicated load.
            always_comb begin
                r_d = r_q;
                if (bus.RW && bus.DA == IDX) begin
                    r_d = wr_val;
                end else if (inc_en && bus.SA == IDX) begin
                    r_d = inc_val;
                end else if (gi == REG_PC && bus.PC_LD) begin
                    r_d = bus.reg_PC_in;
                end else if (gi == REG_SP && bus.SP_LD) begin
                    r_d = bus.reg_SP_in;
                end else if (gi == REG_SR && bus.SR_LD) begin
                    r_d = bus.reg_SR_in;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_q <= (gi == REG_PC) ? (RST_VEC & ~DATA_W'(1)) : '0;
                end else begin
                    r_q <= r_d;
                end
            end

            assign rd_arr[gi] = r_q;
        end
    end

    always_comb begin
        bus.Sout = rd_arr[bus.SA];
        if (cg_hit) begin
            bus.Sout = cg_val;
        end else if (BYPASS != 0 && bus.RW && bus.DA == bus.SA) begin
            bus.Sout = wr_val;
        end
        bus.Dout = rd_arr[bus.DA];
        if (bus.DA == A_CG) begin
            bus.Dout = '0;
        end else if (BYPASS != 0 && bus.RW) begin
            bus.Dout = wr_val;
        end
    end

    assign bus.reg_PC_out = rd_arr[REG_PC];
    assign bus.reg_SP_out = rd_arr[REG_SP];
    assign bus.reg_SR_out = rd_arr[REG_SR];
    assign bus.CG_hit     = cg_hit;

endmodule

// File: tb/tb_reg_file_mp.sv
// Three register-file instances (bypass, no bypass, 20-bit/8-register) share one
// stimulus stream and are checked every cycle against an array-based model.
module tb_reg_file_mp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] rv16 = 16'hC001;
    logic [19:0] rv20 = 20'hC001;

    initial forever #5 clk = ~clk;

    reg_file_mp_if #(.DATA_W(16), .ADDR_W(4)) if0 ();
    reg_file_mp_if #(.DATA_W(16), .ADDR_W(4)) if1 ();
    reg_file_mp_if #(.DATA_W(20), .ADDR_W(3)) if2 ();

    reg_file_mp #(.DATA_W(16), .ADDR_W(4), .BYPASS(1)) dut0 (.clk(clk), .rst(rst), .RST_VEC(rv16), .bus(if0));
    reg_file_mp #(.DATA_W(16), .ADDR_W(4), .BYPASS(0)) dut1 (.clk(clk), .rst(rst), .RST_VEC(rv16), .bus(if1));
    reg_file_mp #(.DATA_W(20), .ADDR_W(3), .BYPASS(1)) dut2 (.clk(clk), .rst(rst), .RST_VEC(rv20), .bus(if2));

    typedef struct packed {
        logic [3:0]  sa;
        logic [3:0]  da;
        logic [1:0]  as_m;
        logic        bw;
        logic        rw;
        logic        ainc;
        logic        pc_ld;
        logic        sp_ld;
        logic        sr_ld;
        logic [31:0] din;
        logic [31:0] pc_in;
        logic [31:0] sp_in;
        logic [31:0] sr_in;
    } stim_t;

    stim_t       st;
    logic [31:0] m_reg [3][16];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          chk_en   = 1'b0;

    // ---------------- behavioural model ----------------
    function automatic int dw(int k);  return (k == 2) ? 20 : 16; endfunction
    function automatic int nr(int k);  return (k == 2) ? 8 : 16;  endfunction
    function automatic bit bp(int k);  return (k != 1);           endfunction
    function automatic logic [31:0] msk(int k); return (32'h1 << dw(k)) - 32'h1; endfunction
    function automatic int sel(logic [3:0] a, int k); return int'(a) % nr(k); endfunction

    function automatic logic [31:0] stored(int k, int r);
        return (r == 3) ? 32'h0 : m_reg[k][r];
    endfunction

    function automatic logic [31:0] wval(int k);
        logic [31:0] v;
        v = st.bw ? {24'h0, st.din[7:0]} : (st.din & msk(k));
        if (sel(st.da, k) < 2) v[0] = 1'b0;
        return v;
    endfunction

    function automatic bit cg_m(int k);
        int s = sel(st.sa, k);
        return (s == 3) || (s == 2 && st.as_m != 2'b00);
    endfunction

    function automatic logic [31:0] cgv_m(int k);
        int s = sel(st.sa, k);
        if (s == 2) return (st.as_m == 2'b10) ? 32'd4 : (st.as_m == 2'b11) ? 32'd8 : 32'd0;
        return (st.as_m == 2'b11) ? msk(k) : 32'(st.as_m);
    endfunction

    function automatic logic [31:0] exp_sout(int k);
        if (cg_m(k)) return cgv_m(k);
        if (bp(k) && st.rw && sel(st.da, k) == sel(st.sa, k)) return wval(k);
        return stored(k, sel(st.sa, k));
    endfunction

    function automatic logic [31:0] exp_dout(int k);
        if (sel(st.da, k) == 3) return 32'h0;
        if (bp(k) && st.rw) return wval(k);
        return stored(k, sel(st.da, k));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 16; r++) m_reg[k][r] = 32'h0;
            m_reg[k][0] = 32'hC001 & msk(k) & ~32'h1;
        end
    endtask

    // Events are applied lowest priority first so later ones overwrite.
    task automatic commit();
        logic [31:0] nxt [16];
        int s, d, amt;
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 16; r++) nxt[r] = m_reg[k][r];
            s = sel(st.sa, k);
            d = sel(st.da, k);
            if (st.pc_ld) nxt[0] = st.pc_in & msk(k);
            if (st.sp_ld) nxt[1] = st.sp_in & msk(k);
            if (st.sr_ld) nxt[2] = st.sr_in & msk(k);
            if (st.ainc && st.as_m == 2'b11 && s != 2 && s != 3) begin
                amt = (s >= 2 && st.bw) ? 1 : 2;
                nxt[s] = (m_reg[k][s] + 32'(amt)) & msk(k);
            end
            if (st.rw && d != 3) nxt[d] = wval(k);
            for (int r = 0; r < 16; r++) m_reg[k][r] = nxt[r];
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(string name, int k, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d t=%0t got=%h expected=%h", name, k, $time, got, exp);
        end
    endtask

    task automatic cmp(int k, logic [31:0] so, logic [31:0] dv, logic [31:0] pc,
                       logic [31:0] sp, logic [31:0] sr, logic cgh);
        check("Sout", k, so, exp_sout(k));
        check("Dout", k, dv, exp_dout(k));
        check("PC_out", k, pc, m_reg[k][0]);
        check("SP_out", k, sp, m_reg[k][1]);
        check("SR_out", k, sr, m_reg[k][2]);
        check("CG_hit", k, 32'(cgh), 32'(cg_m(k)));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, 32'(if0.Sout), 32'(if0.Dout), 32'(if0.reg_PC_out), 32'(if0.reg_SP_out), 32'(if0.reg_SR_out), if0.CG_hit);
            cmp(1, 32'(if1.Sout), 32'(if1.Dout), 32'(if1.reg_PC_out), 32'(if1.reg_SP_out), 32'(if1.reg_SR_out), if1.CG_hit);
            cmp(2, 32'(if2.Sout), 32'(if2.Dout), 32'(if2.reg_PC_out), 32'(if2.reg_SP_out), 32'(if2.reg_SR_out), if2.CG_hit);
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply();
        if0.SA = st.sa; if0.DA = st.da; if0.As = st.as_m; if0.BW = st.bw; if0.RW = st.rw; if0.AINC = st.ainc;
        if0.Din = st.din[15:0]; if0.reg_PC_in = st.pc_in[15:0]; if0.reg_SP_in = st.sp_in[15:0]; if0.reg_SR_in = st.sr_in[15:0];
        if0.PC_LD = st.pc_ld; if0.SP_LD = st.sp_ld; if0.SR_LD = st.sr_ld;
        if1.SA = st.sa; if1.DA = st.da; if1.As = st.as_m; if1.BW = st.bw; if1.RW = st.rw; if1.AINC = st.ainc;
        if1.Din = st.din[15:0]; if1.reg_PC_in = st.pc_in[15:0]; if1.reg_SP_in = st.sp_in[15:0]; if1.reg_SR_in = st.sr_in[15:0];
        if1.PC_LD = st.pc_ld; if1.SP_LD = st.sp_ld; if1.SR_LD = st.sr_ld;
        if2.SA = st.sa[2:0]; if2.DA = st.da[2:0]; if2.As = st.as_m; if2.BW = st.bw; if2.RW = st.rw; if2.AINC = st.ainc;
        if2.Din = st.din[19:0]; if2.reg_PC_in = st.pc_in[19:0]; if2.reg_SP_in = st.sp_in[19:0]; if2.reg_SR_in = st.sr_in[19:0];
        if2.PC_LD = st.pc_ld; if2.SP_LD = st.sp_ld; if2.SR_LD = st.sr_ld;
    endtask

    task automatic settle();
        apply();
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) commit();
        #1;
    endtask

    initial begin
        st = '0;
        apply();
        #1;
        rst = 1'b0;
        model_reset();
        chk_en = 1'b1;

        // Reset state: PC from vector with LSB cleared, everything else zero.
        for (int r = 4; r < 16; r++) begin
            st.sa = 4'(r);
            settle();
            check("rst_Rn", 0, 32'(if0.Sout), 32'h0);
            tick();
        end
        check("rst_PC", 0, 32'(if0.reg_PC_out), 32'hC000);
        check("rst_SP", 0, 32'(if0.reg_SP_out), 32'h0);
        check("rst_SR", 0, 32'(if0.reg_SR_out), 32'h0);
        check("rst_PC20", 2, 32'(if2.reg_PC_out), 32'hC000);
        rst = 1'b1;

        // A reset that covers the clock edge aborts the pending write.
        st = '0; st.rw = 1'b1; st.da = 4'd5; st.din = 32'h1234;
        settle();
        rst = 1'b0;
        model_reset();
        tick();
        rst = 1'b1;
        st = '0; st.sa = 4'd5;
        settle();
        check("abort_R5", 0, 32'(if0.Sout), 32'h0);
        tick();

        // Constant generator.
        for (int a = 0; a < 4; a++) begin
            logic [31:0] cg_exp [4];
            cg_exp[0] = 32'h0; cg_exp[1] = 32'h1; cg_exp[2] = 32'h2; cg_exp[3] = 32'hFFFF;
            st = '0; st.sa = 4'd3; st.as_m = 2'(a);
            settle();
            check("cg_r3", 0, 32'(if0.Sout), cg_exp[a]);
            check("cg_hit", 0, 32'(if0.CG_hit), 32'h1);
            tick();
        end
        st = '0; st.sa = 4'd3; st.as_m = 2'b11;
        settle();
        check("cg_r3_20b", 2, 32'(if2.Sout), 32'hFFFFF);
        tick();
        st = '0; st.sa = 4'd2; st.as_m = 2'b11;
        settle();
        check("cg_r2_8", 0, 32'(if0.Sout), 32'h8);
        tick();

        // Byte write with same-cycle read, with and without bypass.
        st = '0; st.rw = 1'b1; st.da = 4'd5; st.din = 32'hA5F3; st.bw = 1'b1; st.sa = 4'd5;
        settle();
        check("byp_on", 0, 32'(if0.Sout), 32'h00F3);
        check("byp_off", 1, 32'(if1.Sout), 32'h0);
        tick();
        st = '0; st.sa = 4'd5;
        settle();
        check("byte_wr", 1, 32'(if1.Sout), 32'h00F3);
        tick();

        // Post-increment wrap on a general register and byte op on SP.
        st = '0; st.rw = 1'b1; st.da = 4'd6; st.din = 32'hFFFF;
        settle(); tick();
        st = '0; st.ainc = 1'b1; st.as_m = 2'b11; st.sa = 4'd6; st.bw = 1'b1;
        settle(); tick();
        st = '0; st.sa = 4'd6;
        settle();
        check("inc_wrap", 0, 32'(if0.Sout), 32'h0);
        check("inc_20b", 2, 32'(if2.Sout), 32'h10000);
        tick();
        st = '0; st.rw = 1'b1; st.da = 4'd1; st.din = 32'h01FE;
        settle(); tick();
        st = '0; st.ainc = 1'b1; st.as_m = 2'b11; st.sa = 4'd1; st.bw = 1'b1;
        settle(); tick();
        check("inc_sp", 0, 32'(if0.reg_SP_out), 32'h0200);

        // Write port beats dedicated PC load; PC LSB is forced low.
        st = '0; st.rw = 1'b1; st.da = 4'd0; st.din = 32'hD000; st.pc_ld = 1'b1; st.pc_in = 32'hC002;
        settle(); tick();
        check("prio_pc", 0, 32'(if0.reg_PC_out), 32'hD000);
        st = '0; st.rw = 1'b1; st.da = 4'd0; st.din = 32'hC003;
        settle(); tick();
        check("pc_lsb", 0, 32'(if0.reg_PC_out), 32'hC002);

        // R3 write discarded while a different register's load commits.
        st = '0; st.rw = 1'b1; st.da = 4'd3; st.din = 32'h1234; st.sr_ld = 1'b1; st.sr_in = 32'h0107; st.sa = 4'd3;
        settle();
        check("r3_dout", 0, 32'(if0.Dout), 32'h0);
        tick();
        st = '0; st.sa = 4'd2; st.da = 4'd3;
        settle();
        check("sr_ld", 0, 32'(if0.reg_SR_out), 32'h0107);
        check("sr_read", 0, 32'(if0.Sout), 32'h0107);
        check("sr_nocg", 0, 32'(if0.CG_hit), 32'h0);
        check("sr_20b", 2, 32'(if2.reg_SR_out), 32'h0107);
        check("r3_read", 0, 32'(if0.Dout), 32'h0);
        tick();

        // Randomised traffic, with occasional mid-cycle resets.
        for (int i = 0; i < 3000; i++) begin
            st.sa    = 4'($urandom);
            st.da    = 4'($urandom);
            st.as_m  = 2'($urandom);
            st.bw    = 1'($urandom);
            st.rw    = ($urandom_range(0, 2) == 0);
            st.ainc  = 1'($urandom);
            st.din   = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
            st.pc_in = $urandom & ~32'h1;
            st.sp_in = $urandom & ~32'h1;
            st.sr_in = $urandom;
            st.pc_ld = ($urandom_range(0, 3) == 0);
            st.sp_ld = ($urandom_range(0, 3) == 0);
            st.sr_ld = ($urandom_range(0, 3) == 0);
            settle();
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                model_reset();
                tick();
                rst = 1'b1;
            end else begin
                tick();
            end
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
